// File: rtl/level_to_pulse_multi_if.sv
// level_to_pulse_multi_if: switch-in / pulse-out bundle for the N-channel level-to-pulse converter
//   chave  : raw asynchronous switch levels, one bit per channel (master -> slave)
//   modo   : edge select 00 rising, 01 falling, 10 both, 11 none (master -> slave)
//   pulso  : per-channel stretched pulse (slave -> master)
//   nivel  : per-channel debounced level (slave -> master)
//   evento : OR of all pulso bits (slave -> master)
interface level_to_pulse_multi_if #(parameter int N = 4);
  logic [N-1:0] chave;
  logic [1:0]   modo;
  logic [N-1:0] pulso;
  logic [N-1:0] nivel;
  logic         evento;
  modport master (output chave, modo, input pulso, nivel, evento);
  modport slave (input chave, modo, output pulso, nivel, evento);
endinterface

// File: rtl/level_to_pulse_multi.sv
// level_to_pulse_multi: N-channel synchronise + debounce + edge-to-stretched-pulse converter
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of level_to_pulse_multi_if (chave/modo in, pulso/nivel/evento out)
module level_to_pulse_multi #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  level_to_pulse_multi_if.slave bus
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(PULSE_LEN + 1);
  logic [N-1:0] pulso, nivel;
  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]          plen_q, plen_d;
    logic                   nivel_q, nivel_d, pulso_q, pulso_d, s, commit, qual;
    always_comb begin
      s       = sync_q[SYNC_STAGES-1];
      commit  = s != nivel_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
      cnt_d   = (s == nivel_q || commit) ? '0 : cnt_q + 1'b1;
      nivel_d = commit ? s : nivel_q;
      // new level 1 matches modo 00, new level 0 matches modo 01; 11 never matches
      qual    = commit && (bus.modo == 2'b10 || bus.modo == {1'b0, ~s});
      plen_d  = qual ? PW'(PULSE_LEN) : plen_q != '0 ? plen_q - 1'b1 : '0;
      // stays high while the decrement has not yet reached zero
      pulso_d = qual || plen_q > PW'(1);
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        plen_q  <= '0;
        nivel_q <= 1'b0;
        pulso_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.chave[c]};
        cnt_q   <= cnt_d;
        plen_q  <= plen_d;
        nivel_q <= nivel_d;
        pulso_q <= pulso_d;
      end
    assign pulso[c] = pulso_q;
    assign nivel[c] = nivel_q;
  end
  assign bus.pulso  = pulso;
  assign bus.nivel  = nivel;
  assign bus.evento = |pulso;
endmodule
